// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// The optional statistics block is enabled with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 32;

  typedef enum logic [0:0] {
    ARB_NORMAL = 1'b0,
    ARB_BURST  = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C    = 2'd1,
    OWN_L    = 2'd2
  } owner_e;

  // True when the word address fits in the aw-bit memory address space.
  function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
    return (addr >> aw) == 32'd0;
  endfunction

endpackage

// File: rtl/dmem_arb_rdtrack.sv
// Registers owner, read-valid and address-error flags for the one-cycle
// read return of the synchronous-read data memory.
module dmem_arb_rdtrack
  import dmem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   rd_issue,
  input  owner_e rd_owner,
  input  logic   err_issue,
  output logic   c_rvalid,
  output logic   l_rvalid,
  output logic   addr_err
);

  owner_e owner_q;
  owner_e owner_d;
  logic   rvalid_q;
  logic   rvalid_d;
  logic   err_q;
  logic   err_d;

  always_comb begin
    rvalid_d = rd_issue;
    owner_d  = rd_issue ? rd_owner : OWN_NONE;
    err_d    = err_issue;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign c_rvalid = rvalid_q && (owner_q == OWN_C);
  assign l_rvalid = rvalid_q && (owner_q == OWN_L);
  assign addr_err = err_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage (C) and a
// loader/debug port (L). Optional counters: define DMEM_ARB_STATS_EN.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [31:0]   c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_stall,
  output logic          c_rvalid,
  input  logic          l_req,
  input  logic          l_we,
  input  logic          l_lock,
  input  logic [31:0]   l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] rdata,
  output logic          addr_err,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_we,
  output logic          m_re,
  input  logic [DW-1:0] m_rdata,
`ifdef DMEM_ARB_STATS_EN
  input  logic          stat_clr,
  output logic [31:0]   stat_c_stall_cycles,
  output logic [31:0]   stat_l_grants,
`endif
  output arb_state_e    dbg_state,
  output logic [7:0]    dbg_starve_cnt
);

  // Handshake: a requester holds req (and its address/data) until it is
  // accepted; C is accepted in any cycle with c_req && !c_stall, L in any
  // cycle with l_gnt. Read data returns exactly one cycle after acceptance.

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e    state_q;
  arb_state_e    state_d;
  logic [SW-1:0] starve_cnt_q;
  logic [SW-1:0] starve_cnt_d;
  logic [BW-1:0] burst_cnt_q;
  logic [BW-1:0] burst_cnt_d;
  logic [AW-1:0] m_addr_q;
  logic [AW-1:0] m_addr_d;
  logic [DW-1:0] m_wdata_q;
  logic [DW-1:0] m_wdata_d;

  owner_e        winner;
  logic          starve_sat;
  logic          burst_hold;
  logic          l_blocked;
  logic [31:0]   win_addr;
  logic [DW-1:0] win_wdata;
  logic          win_we;
  logic          addr_ok;
  logic          issue;

  always_comb begin
    starve_sat = (starve_cnt_q == SW'(STARVE_LIMIT));
    burst_hold = (state_q == ARB_BURST) && l_req && l_lock &&
                 (burst_cnt_q < BW'(MAX_BURST));
    // The cycle after a full-length burst is reserved for the CPU.
    l_blocked  = (state_q == ARB_BURST) && (burst_cnt_q == BW'(MAX_BURST));

    winner = OWN_NONE;
    if (burst_hold) begin
      winner = OWN_L;
    end else if (l_req && !l_blocked && (!c_req || starve_sat)) begin
      winner = OWN_L;
    end else if (c_req) begin
      winner = OWN_C;
    end
  end

  always_comb begin
    state_d     = ARB_NORMAL;
    burst_cnt_d = '0;
    if ((winner == OWN_L) && l_lock) begin
      state_d     = ARB_BURST;
      burst_cnt_d = burst_hold ? (burst_cnt_q + BW'(1)) : BW'(1);
    end

    starve_cnt_d = starve_cnt_q;
    if (!l_req || (winner == OWN_L)) begin
      starve_cnt_d = '0;
    end else if (!starve_sat) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  always_comb begin
    win_addr  = (winner == OWN_L) ? l_addr  : c_addr;
    win_wdata = (winner == OWN_L) ? l_wdata : c_wdata;
    win_we    = (winner == OWN_L) ? l_we    : c_we;
    addr_ok   = addr_in_range(win_addr, AW);
    issue     = (winner != OWN_NONE) && addr_ok;

    m_addr_d  = issue ? win_addr[AW-1:0] : m_addr_q;
    m_wdata_d = issue ? win_wdata        : m_wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_NORMAL;
      starve_cnt_q <= '0;
      burst_cnt_q  <= '0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
    end
  end

  assign c_stall = c_req && (winner != OWN_C);
  assign l_gnt   = (winner == OWN_L);
  assign m_we    = issue && win_we;
  assign m_re    = issue && !win_we;
  assign m_addr  = m_addr_d;
  assign m_wdata = m_wdata_d;
  assign rdata   = m_rdata;

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = 8'(starve_cnt_q);

  dmem_arb_rdtrack u_rdtrack (
    .clk       (clk),
    .rst       (rst),
    .rd_issue  (m_re),
    .rd_owner  (winner),
    .err_issue ((winner != OWN_NONE) && !addr_ok),
    .c_rvalid  (c_rvalid),
    .l_rvalid  (l_rvalid),
    .addr_err  (addr_err)
  );

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_c_q;
  logic [31:0] stat_c_d;
  logic [31:0] stat_l_q;
  logic [31:0] stat_l_d;

  always_comb begin
    stat_c_d = stat_c_q + {31'd0, c_stall};
    stat_l_d = stat_l_q + {31'd0, l_gnt};
    if (stat_clr) begin
      stat_c_d = '0;
      stat_l_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_c_q <= '0;
      stat_l_q <= '0;
    end else begin
      stat_c_q <= stat_c_d;
      stat_l_q <= stat_l_d;
    end
  end

  assign stat_c_stall_cycles = stat_c_q;
  assign stat_l_grants       = stat_l_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a behavioural
// synchronous-read memory preloaded with mem[i] = i.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          c_req;
  logic          c_we;
  logic [31:0]   c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_stall;
  logic          c_rvalid;
  logic          l_req;
  logic          l_we;
  logic          l_lock;
  logic [31:0]   l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] rdata;
  logic          addr_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic          m_re;
  logic [DW-1:0] m_rdata;
  arb_state_e    dbg_state;
  logic [7:0]    dbg_starve_cnt;
`ifdef DMEM_ARB_STATS_EN
  logic          stat_clr;
  logic [31:0]   stat_c_stall_cycles;
  logic [31:0]   stat_l_grants;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW:0] exp_q[$];
  logic [DW-1:0] mem [0:255];

  dmem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .MAX_BURST(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .c_req          (c_req),
    .c_we           (c_we),
    .c_addr         (c_addr),
    .c_wdata        (c_wdata),
    .c_stall        (c_stall),
    .c_rvalid       (c_rvalid),
    .l_req          (l_req),
    .l_we           (l_we),
    .l_lock         (l_lock),
    .l_addr         (l_addr),
    .l_wdata        (l_wdata),
    .l_gnt          (l_gnt),
    .l_rvalid       (l_rvalid),
    .rdata          (rdata),
    .addr_err       (addr_err),
    .m_addr         (m_addr),
    .m_wdata        (m_wdata),
    .m_we           (m_we),
    .m_re           (m_re),
    .m_rdata        (m_rdata),
`ifdef DMEM_ARB_STATS_EN
    .stat_clr            (stat_clr),
    .stat_c_stall_cycles (stat_c_stall_cycles),
    .stat_l_grants       (stat_l_grants),
`endif
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write and registered read on the rising edge
  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= m_wdata;
    if (m_re) m_rdata <= mem[m_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Scoreboard: {is_l, data} pushed at grant, popped when rvalid appears
  always @(negedge clk) begin
    if (!rst && (c_rvalid || l_rvalid)) begin
      if (exp_q.size() == 0) check("rvalid_unexpected", {c_rvalid, l_rvalid}, 64'd0);
      else check("rdata", {31'd0, l_rvalid, rdata}, {31'd0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_lock = 0; l_addr = 0; l_wdata = 0;
  endtask

  task automatic scen_starve();
    for (int k = 1; k <= 6; k++) begin
      step();
      c_req = 1; c_we = 0; c_addr = 32'(k);
      l_req = (k <= 5); l_we = 1; l_lock = 0; l_addr = 10; l_wdata = 32'hAA;
      @(negedge clk);
      check("starve_cnt", dbg_starve_cnt, (k <= 5) ? 64'(k - 1) : 64'd0);
      check("s2_l_gnt", l_gnt, (k == 5) ? 64'd1 : 64'd0);
      check("s2_c_stall", c_stall, (k == 5) ? 64'd1 : 64'd0);
      if (k == 5) begin
        check("s2_m_we", m_we, 1);
        check("s2_m_addr", m_addr, 10);
        check("s2_m_wdata", m_wdata, 32'hAA);
      end else begin
        exp_q.push_back({1'b0, 32'(k)});
      end
    end
    step();
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'(i);
    m_rdata = '0;
    rst = 1;
    idle_inputs();
`ifdef DMEM_ARB_STATS_EN
    stat_clr = 0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_c_rvalid", c_rvalid, 0);
    check("rst_l_rvalid", l_rvalid, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_state", dbg_state, ARB_NORMAL);
    check("rst_starve", dbg_starve_cnt, 0);
    step();
    rst = 0;

    // CPU read of address 5
    step();
    c_req = 1; c_we = 0; c_addr = 5;
    @(negedge clk);
    check("s1_c_stall", c_stall, 0);
    check("s1_m_re", m_re, 1);
    check("s1_m_addr", m_addr, 5);
    exp_q.push_back({1'b0, 32'd5});
    step();
    idle_inputs();
    @(negedge clk);
    check("s1_c_rvalid", c_rvalid, 1);

    // Starvation-forced loader write, then loader read-back
    scen_starve();
    step();
    l_req = 1; l_we = 0; l_addr = 10;
    @(negedge clk);
    check("rb_l_gnt", l_gnt, 1);
    check("rb_m_re", m_re, 1);
    exp_q.push_back({1'b1, 32'hAA});
    step();
    idle_inputs();

    // Locked loader burst with CPU request arriving mid-burst
    for (int k = 1; k <= 12; k++) begin
      step();
      l_req = 1; l_lock = 1; l_we = 0; l_addr = 32'(20 + k);
      c_req = (k >= 4 && k <= 9); c_we = 0; c_addr = 30;
      @(negedge clk);
      check("s3_l_gnt", l_gnt, (k <= 8 || k >= 10) ? 64'd1 : 64'd0);
      check("s3_c_stall", c_stall, (k >= 4 && k <= 8) ? 64'd1 : 64'd0);
      if (k == 9) check("s3_state", dbg_state, ARB_BURST);
      if (l_gnt) exp_q.push_back({1'b1, 32'(20 + k)});
      else if (c_req && !c_stall) exp_q.push_back({1'b0, 32'd30});
    end
    step();
    idle_inputs();
    step();
    @(negedge clk);
    check("s3_state_end", dbg_state, ARB_NORMAL);

    // Out-of-range CPU address
    step();
    c_req = 1; c_we = 0; c_addr = 32'h100;
    @(negedge clk);
    check("s4_c_stall", c_stall, 0);
    check("s4_m_re", m_re, 0);
    check("s4_m_we", m_we, 0);
    step();
    idle_inputs();
    @(negedge clk);
    check("s4_addr_err", addr_err, 1);
    check("s4_c_rvalid", c_rvalid, 0);
    step();
    @(negedge clk);
    check("s4_addr_err_clr", addr_err, 0);

    // Random CPU reads with the loader idle
    for (int k = 0; k < 16; k++) begin
      int a;
      a = $urandom_range(0, 9);
      step();
      c_req = 1; c_we = 0; c_addr = 32'(a);
      @(negedge clk);
      check("rnd_c_stall", c_stall, 0);
      exp_q.push_back({1'b0, 32'(a)});
    end
    step();
    idle_inputs();
    step();

    // Reset while a locked loader read is outstanding
    step();
    l_req = 1; l_lock = 1; l_we = 0; l_addr = 7;
    @(negedge clk);
    check("s5_l_gnt", l_gnt, 1);
    step();
    rst = 1;
    idle_inputs();
    @(negedge clk);
    check("s5_l_rvalid_rst", l_rvalid, 0);
    check("s5_state", dbg_state, ARB_NORMAL);
    check("s5_starve", dbg_starve_cnt, 0);
    step();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("s5_l_rvalid", l_rvalid, 0);
      step();
    end

    scen_starve();
    step();
`ifdef DMEM_ARB_STATS_EN
    @(negedge clk);
    check("stat_c_stall", stat_c_stall_cycles, 1);
    check("stat_l_grants", stat_l_grants, 1);
    step();
    stat_clr = 1;
    step();
    stat_clr = 0;
    @(negedge clk);
    check("stat_c_clr", stat_c_stall_cycles, 0);
    check("stat_l_clr", stat_l_grants, 0);
`endif
    repeat (3) step();
    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
